imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction loader sitting directly upstream of the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory from word address 0. It holds the core in reset until a complete, checksum-verified image has been written.

## Interface
- ADDR_WIDTH, 10: instruction-memory word-address width.
- MAX_WORDS, 1024: largest accepted image length in words; must be ≤ 2^ADDR_WIDTH.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  `in_data` holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  word address for the write.
- mem_wdata  out  32  instruction word for the write.
- core_rst_n  out  1  drives the core's active-low `rst`; 1 only after a successful load.
- done  out  1  image loaded and verified; sticky until `rst`.
- error  out  1  length or checksum failure; sticky until `rst`.
- load_count  out  16  number of words written so far.

## Operation
- A byte is accepted on any rising edge where `in_valid && in_ready`. No other byte is consumed.
- Stream format:
  - N_lo, N_hi: word count N, 16-bit little-endian.
  - 4N data bytes, each word least-significant byte first.
  - One checksum byte equal to the XOR of the 4N data bytes. Length bytes are excluded.
- FSM states: LEN0 → LEN1 → DATA → CSUM → RUN, plus ERROR.
  - LEN0: accept N_lo.
  - LEN1: accept N_hi. If N==0 or N>MAX_WORDS, go to ERROR; otherwise go to DATA.
  - DATA: a 2-bit byte counter shifts bytes into a word register. On the 4th byte, issue a write to the current word address and increment it. After word N−1 is written, go to CSUM.
  - CSUM: accept one byte. A match with the running XOR goes to RUN; a mismatch goes to ERROR.
  - RUN and ERROR are terminal; only `rst` leaves them.
- `in_ready` is 1 in LEN0, LEN1, DATA and CSUM. It is 0 in RUN and ERROR, and 0 while `rst` is high.
- Running XOR and word-address counter: cleared in LEN0, updated only in DATA.
- A failed load leaves already-written words in memory; there is no rollback.
- `load_count` increments with each `mem_we` pulse and saturates at N.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_rst_n`=0, `done`=0, `error`=0, `load_count`=0, state=LEN0.
- `in_ready`=1 on the first cycle after `rst` deasserts.
- Write latency: when the 4th byte of word k is accepted at edge e, `mem_we`=1 for exactly the cycle following e, with `mem_addr`=k and `mem_wdata` = the assembled word.
- Checksum byte accepted at edge c:
  - On a match, `done`=1 and `core_rst_n`=1 from the cycle after c.
  - On a mismatch, `error`=1 from the cycle after c.
- An invalid N_hi accepted at edge h gives `error`=1 from the cycle after h.
- `in_valid` gaps of any length stall the FSM with no effect on counters or outputs.
- Reset mid-load: at the edge where `rst` is sampled high, all state returns to LEN0 and the partial word is discarded. `mem_we` is 0 from that edge on. A subsequent load starts again at address 0.
- `done` and `error` are never both 1.

## Test plan
- Reset, then send 02 00 93 00 50 00 13 01 A0 00 71 back-to-back.
  - Required: `mem_we` pulses write addr0=0x00500093 and addr1=0x00A00113.
  - Required: `done`=1, `core_rst_n`=1, `load_count`=2, `in_ready`=0.
- Same stream with `in_valid` high only every other cycle.
  - Required: identical writes, each `mem_we` exactly one cycle wide, identical final state.
- Same stream with checksum 0x70.
  - Required: both words written, then `error`=1, `core_rst_n`=0, `done`=0, `in_ready`=0.
- Length N=0 (00 00), then separately N=MAX_WORDS+1.
  - Required: `error`=1 one cycle after the second byte, no `mem_we` pulse, `in_ready`=0.
- Assert `rst` for one cycle after 5 data bytes of the first case, then resend the full first-case stream.
  - Required: no write for the partial second word.
  - Required: the second run writes addr0 and addr1 correctly and ends with `done`=1.
- After RUN, hold `in_valid`=1 for 20 cycles with random data.
  - Required: `in_ready`=0, no `mem_we`, and `done`, `core_rst_n` and `load_count` unchanged.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Bundles the loader's byte-stream handshake and its
//               instruction-memory write port.
//   in_valid   stream byte present (source -> loader)
//   in_data    stream byte, 8 bits (source -> loader)
//   in_ready   loader accepts a byte this cycle (loader -> source)
//   mem_we     one-cycle instruction-memory write strobe (loader -> memory)
//   mem_addr   word address of the write (loader -> memory)
//   mem_wdata  32-bit instruction word (loader -> memory)
//   modport slave  : the loader side
//   modport master : the stream source / memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction loader. Receives a length-prefixed,
//               XOR-checksummed byte stream, packs little-endian 32-bit
//               words and writes them to instruction memory from address 0.
//               The core is held in reset until the whole image has been
//               written and its checksum matches.
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        stream handshake + memory write port (slave modport)
//   core_rst_n active-low reset for the core, 1 only after a good load
//   done       image loaded and verified (sticky until rst)
//   error      bad length or checksum (sticky until rst)
//   load_count words written so far, saturating at the image length
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  wire logic        clk,
    input  wire logic        rst,
    imem_loader_if.slave     bus,
    output logic             core_rst_n,
    output logic             done,
    output logic             error,
    output logic [15:0]      load_count
);

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           word_q, word_d;       // low three bytes of the word in flight
    logic [7:0]            xor_q, xor_d;
    logic [15:0]           words_q, words_d;     // next word address / words issued
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [15:0]           load_count_q, load_count_d;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [15:0]           w_len_rx;

    // Ready is gated by rst directly so nothing is offered while reset is held.
    assign w_in_ready = !rst && ((state_q == S_LEN0) || (state_q == S_LEN1) ||
                                 (state_q == S_DATA) || (state_q == S_CSUM));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_len_rx   = {bus.in_data, len_lo_q};

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        xor_d        = xor_q;
        words_d      = words_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            S_LEN0: begin
                xor_d      = 8'h00;
                words_d    = 16'h0000;
                byte_cnt_d = 2'd0;
                if (w_accept) begin
                    len_lo_d = bus.in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_accept) begin
                    len_d = w_len_rx;
                    if ((w_len_rx == 16'h0000) || ({1'b0, w_len_rx} > c_max_words)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    xor_d      = xor_q ^ bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Last byte is the MSB: write straight from the
                        // incoming byte plus the three buffered ones.
                        mem_we_d    = 1'b1;
                        mem_addr_d  = words_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {bus.in_data, word_q};
                        words_d     = words_q + 16'd1;
                        if ((words_q + 16'd1) == len_q) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        // Shift right so byte 0 ends up in bits [7:0].
                        word_d = {bus.in_data, word_q[23:8]};
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (bus.in_data == xor_q) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                // S_RUN / S_ERROR are terminal until rst.
            end
        endcase

        load_count_d = load_count_q;
        if (mem_we_q && (load_count_q != len_q)) begin
            load_count_d = load_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LEN0;
            len_lo_q     <= 8'h00;
            len_q        <= 16'h0000;
            byte_cnt_q   <= 2'd0;
            word_q       <= 24'h000000;
            xor_q        <= 8'h00;
            words_q      <= 16'h0000;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h00000000;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            load_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            xor_q        <= xor_d;
            words_q      <= words_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            error_q      <= error_d;
            load_count_q <= load_count_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign core_rst_n    = done_q;
    assign done          = done_q;
    assign error         = error_q;
    assign load_count    = load_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Stimulus pushes each
//               expected memory write (address, word, cycle) into a queue;
//               a negedge monitor pops and compares every mem_we pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        core_rst_n;
    logic        done;
    logic        error;
    logic [15:0] load_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    wr_t exp_q[$];

    logic [31:0] img [2];

    imem_loader_if #(.ADDR_WIDTH(10)) bus ();

    imem_loader #(
        .ADDR_WIDTH (10),
        .MAX_WORDS  (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%08h, required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%08h cyc=%0d, required addr=%0h data=%08h cyc=%0d",
                             bus.mem_addr, bus.mem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Write must appear in the cycle right after the accepting edge.
    task automatic expect_write(input logic [9:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic send(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %02h not accepted within 20 cycles", b);
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {22'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_flags", {28'b0, core_rst_n, done, error, 1'b0}, 32'd0);
        check("rst_load_count", {16'b0, load_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic send_image(input int gap, input logic [7:0] csum);
        send(8'h02, gap);
        send(8'h00, gap);
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 4; b++) begin
                send(img[w][8*b +: 8], gap);
            end
            expect_write(w[9:0], img[w]);
        end
        send(csum, gap);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_success(input string tag);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_core_rst_n"}, {31'b0, core_rst_n}, 32'd1);
        check({tag, "_error"}, {31'b0, error}, 32'd0);
        check({tag, "_load_count"}, {16'b0, load_count}, 32'd2);
        check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
    endtask

    initial begin
        int bad;
        img[0] = 32'h00500093;
        img[1] = 32'h00A00113;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Back-to-back good image
        do_reset();
        send_image(0, 8'h71);
        check_success("b2b");
        drain("b2b_pending");

        // Terminal RUN: random traffic must be ignored
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (bus.in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("run_in_ready_high_cycles", bad, 32'd0);
        check_success("run_hold");

        // Gapped stream
        do_reset();
        send_image(1, 8'h71);
        check_success("gap");
        drain("gap_pending");

        // Bad checksum
        do_reset();
        send_image(0, 8'h70);
        check("csum_error", {31'b0, error}, 32'd1);
        check("csum_done", {31'b0, done}, 32'd0);
        check("csum_core_rst_n", {31'b0, core_rst_n}, 32'd0);
        check("csum_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("csum_load_count", {16'b0, load_count}, 32'd2);
        drain("csum_pending");

        // N = 0
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        check("n0_error", {31'b0, error}, 32'd1);
        check("n0_done", {31'b0, done}, 32'd0);
        check("n0_in_ready", {31'b0, bus.in_ready}, 32'd0);
        drain("n0_pending");

        // N = MAX_WORDS + 1 = 0x0401
        do_reset();
        send(8'h01, 0);
        send(8'h04, 0);
        check("nmax_error", {31'b0, error}, 32'd1);
        check("nmax_done", {31'b0, done}, 32'd0);
        check("nmax_in_ready", {31'b0, bus.in_ready}, 32'd0);
        drain("nmax_pending");

        // Reset after 5 data bytes, then a full reload
        do_reset();
        send(8'h02, 0);
        send(8'h00, 0);
        for (int b = 0; b < 4; b++) send(img[0][8*b +: 8], 0);
        expect_write(10'd0, img[0]);
        send(img[1][7:0], 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_load_count", {16'b0, load_count}, 32'd0);
        drain("midrst_pending");
        send_image(0, 8'h71);
        check_success("reload");
        drain("reload_pending");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
